pc_stack: RTL and testbench

Program counter and 2-level hardware return stack for the PIC16C5x core. It sits directly upstream of program memory: `pcOut` drives the memory's `PCIn` address every cycle. It applies the control-flow effect of the instruction in the execute stage: increment, skip, GOTO, CALL, RETLW or a write to PCL. It also raises `flush` whenever the instruction already fetched must be discarded.

---
 rtl/pc_stack.sv | 125 ++++++++++++
 tb/tb_pc_stack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter and shift-register return stack for a PIC16C5x core.
// Ports: clk, rst (sync, active-high), stall, pcOp/kIn/pclIn/paIn in;
// pcOut (fetch address), flush, stackDepth, stackOvf, stackUnf out.
module pc_stack #(
  parameter  int PC_WIDTH = 11,
  parameter  int DEPTH    = 2,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [2:0]          pcOp,
  input  logic [8:0]          kIn,
  input  logic [7:0]          pclIn,
  input  logic [1:0]          paIn,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic                flush,
  output logic [DW-1:0]       stackDepth,
  output logic                stackOvf,
  output logic                stackUnf
);

  typedef enum logic [2:0] {
    OP_INC   = 3'b000,
    OP_SKIP  = 3'b001,
    OP_GOTO  = 3'b010,
    OP_CALL  = 3'b011,
    OP_RETLW = 3'b100,
    OP_PCLWR = 3'b101
  } pc_op_e;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] stk_q [DEPTH];
  logic [PC_WIDTH-1:0] stk_d [DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                flush_q, flush_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push, pop;
  logic                full, empty;

  // Targets built at full 11-bit width, then trimmed; at narrower
  // widths the upper page bits simply fall off.
  logic [10:0]         goto_w, call_w, pcl_w;
  logic [PC_WIDTH-1:0] pc_inc;

  assign goto_w = {paIn, kIn};
  assign call_w = {paIn, 1'b0, kIn[7:0]};
  assign pcl_w  = {paIn, 1'b0, pclIn};
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);

  always_comb begin
    pc_d    = pc_q;
    flush_d = flush_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (!stall) begin
      flush_d = 1'b1;
      case (pcOp)
        OP_SKIP:  pc_d = pc_inc;
        OP_GOTO:  pc_d = goto_w[PC_WIDTH-1:0];
        OP_CALL: begin
          pc_d = call_w[PC_WIDTH-1:0];
          push = 1'b1;
        end
        OP_RETLW: begin
          pc_d = stk_q[0];
          pop  = 1'b1;
        end
        OP_PCLWR: pc_d = pcl_w[PC_WIDTH-1:0];
        default: begin
          pc_d    = pc_inc;
          flush_d = 1'b0;
        end
      endcase
      // pcOut is already the return address of the executing CALL.
      if (push) begin
        for (int i = 1; i < DEPTH; i++)
          stk_d[i] = stk_q[i-1];
        stk_d[0] = pc_q;
        if (full) ovf_d = 1'b1;
        else      depth_d = depth_q + DW'(1);
      end
      // Bottom entry is kept, so over-popping repeats it.
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++)
          stk_d[i] = stk_q[i+1];
        if (empty) unf_d = 1'b1;
        else       depth_d = depth_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '1;
      flush_q <= 1'b1;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        stk_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stk_q   <= stk_d;
    end
  end

  assign pcOut      = pc_q;
  assign flush      = flush_q;
  assign stackDepth = depth_q;
  assign stackOvf   = ovf_q;
  assign stackUnf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack: directed vector table plus randomized run
// against a queue-based reference model.
module tb_pc_stack;

  localparam int PCW   = 11;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stall = 1'b0;
  logic [2:0]     pcOp = 3'd0;
  logic [8:0]     kIn = 9'd0;
  logic [7:0]     pclIn = 8'd0;
  logic [1:0]     paIn = 2'd0;
  logic [PCW-1:0] pcOut;
  logic           flush;
  logic [1:0]     stackDepth;
  logic           stackOvf;
  logic           stackUnf;

  always #5 clk = ~clk;

  pc_stack #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pcOp(pcOp),
    .kIn(kIn), .pclIn(pclIn), .paIn(paIn),
    .pcOut(pcOut), .flush(flush), .stackDepth(stackDepth),
    .stackOvf(stackOvf), .stackUnf(stackUnf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit r; bit s; int op; int k; int pcl; int pa;
    int pc; int fl; int dp; int ov; int un;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit r, bit s, int op, int k, int pcl,
                              int pa, int pc, int fl, int dp,
                              int ov, int un);
    vec_t v;
    v.r = r; v.s = s; v.op = op; v.k = k; v.pcl = pcl; v.pa = pa;
    v.pc = pc; v.fl = fl; v.dp = dp; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic drive(input bit r, input bit s, input int op,
                       input int k, input int pcl, input int pa);
    rst   = r;
    stall = s;
    pcOp  = 3'(op);
    kIn   = 9'(k);
    pclIn = 8'(pcl);
    paIn  = 2'(pa);
    @(posedge clk);
    #1;
  endtask

  // Reference model: return stack as a fixed-length queue, top first.
  int m_pc, m_fl, m_dp, m_ov, m_un;
  int m_q [$];

  task automatic model_step(input bit r, input bit s, input int op,
                            input int k, input int pcl, input int pa);
    int ret;
    if (r) begin
      m_pc = (1 << PCW) - 1;
      m_fl = 1; m_dp = 0; m_ov = 0; m_un = 0;
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_q.push_back(0);
      return;
    end
    if (s) return;
    m_fl = 1;
    case (op)
      1: m_pc = (m_pc + 1) % (1 << PCW);
      2: m_pc = pa * 512 + k;
      3: begin
        m_q.push_front(m_pc);
        void'(m_q.pop_back());
        if (m_dp == DEPTH) m_ov = 1; else m_dp++;
        m_pc = pa * 512 + (k % 256);
      end
      4: begin
        ret = m_q[0];
        m_q.delete(0);
        m_q.push_back(m_q[$]);
        if (m_dp == 0) m_un = 1; else m_dp--;
        m_pc = ret;
      end
      5: m_pc = pa * 512 + pcl;
      default: begin
        m_pc = (m_pc + 1) % (1 << PCW);
        m_fl = 0;
      end
    endcase
  endtask

  initial begin
    // r s op k pcl pa | pc fl dp ov un
    tbl.push_back(mk(1,0,0,0,0,0, 'h7FF,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 'h7FF,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 'h000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 'h001,0,0,0,0));
    tbl.push_back(mk(0,0,2,'h1A5,0,1, 'h3A5,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 'h3A6,0,0,0,0));
    tbl.push_back(mk(0,0,2,'h010,0,0, 'h010,1,0,0,0));
    tbl.push_back(mk(0,0,3,'h1F3,0,2, 'h4F3,1,1,0,0));
    tbl.push_back(mk(0,0,4,0,0,0, 'h010,1,0,0,0));
    tbl.push_back(mk(0,0,2,'h100,0,0, 'h100,1,0,0,0));
    tbl.push_back(mk(0,0,3,0,0,1, 'h200,1,1,0,0));
    tbl.push_back(mk(0,0,3,0,0,1, 'h200,1,2,0,0));
    tbl.push_back(mk(0,0,2,'h100,0,1, 'h300,1,2,0,0));
    tbl.push_back(mk(0,0,3,0,0,0, 'h000,1,2,1,0));
    tbl.push_back(mk(0,0,4,0,0,0, 'h300,1,1,1,0));
    tbl.push_back(mk(0,0,4,0,0,0, 'h200,1,0,1,0));
    tbl.push_back(mk(0,0,4,0,0,0, 'h200,1,0,1,1));
    tbl.push_back(mk(0,0,5,0,'h80,0, 'h080,1,0,1,1));
    tbl.push_back(mk(0,0,2,'h050,0,0, 'h050,1,0,1,1));
    tbl.push_back(mk(0,0,1,0,0,0, 'h051,1,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0, 'h052,0,0,1,1));
    tbl.push_back(mk(0,0,6,0,0,0, 'h053,0,0,1,1));
    tbl.push_back(mk(0,1,2,'h0AA,0,0, 'h053,0,0,1,1));
    tbl.push_back(mk(0,1,2,'h0AA,0,0, 'h053,0,0,1,1));
    tbl.push_back(mk(0,1,2,'h0AA,0,0, 'h053,0,0,1,1));
    tbl.push_back(mk(1,1,3,'h0FF,0,3, 'h7FF,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 'h000,0,0,0,0));
    tbl.push_back(mk(0,0,2,'h0AA,0,0, 'h0AA,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 'h0AA,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 'h0AB,0,0,0,0));
    tbl.push_back(mk(0,0,7,0,0,0, 'h0AC,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].op, tbl[i].k,
            tbl[i].pcl, tbl[i].pa);
      check($sformatf("vec%0d pcOut", i), int'(pcOut), tbl[i].pc);
      check($sformatf("vec%0d flush", i), int'(flush), tbl[i].fl);
      check($sformatf("vec%0d depth", i), int'(stackDepth), tbl[i].dp);
      check($sformatf("vec%0d ovf", i), int'(stackOvf), tbl[i].ov);
      check($sformatf("vec%0d unf", i), int'(stackUnf), tbl[i].un);
    end

    // Hand-written: CALL then RETLW back to back, twice nested.
    drive(1,0,0,0,0,0);
    drive(0,0,2,'h020,0,0);
    drive(0,0,3,'h040,0,1);
    drive(0,0,3,'h060,0,2);
    check("nest pcOut", int'(pcOut), 'h460);
    drive(0,0,4,0,0,0);
    check("nest ret1", int'(pcOut), 'h240);
    drive(0,0,4,0,0,0);
    check("nest ret2", int'(pcOut), 'h020);
    check("nest depth", int'(stackDepth), 0);
    check("nest unf", int'(stackUnf), 0);

    // Randomized run against the model.
    model_step(1,0,0,0,0,0);
    drive(1,0,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r, s;
      int op, k, pcl, pa;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 7) == 0);
      op  = $urandom_range(0, 7);
      k   = $urandom_range(0, 511);
      pcl = $urandom_range(0, 255);
      pa  = $urandom_range(0, 3);
      model_step(r, s, op, k, pcl, pa);
      drive(r, s, op, k, pcl, pa);
      check($sformatf("rnd%0d pcOut", n), int'(pcOut), m_pc);
      check($sformatf("rnd%0d flush", n), int'(flush), m_fl);
      check($sformatf("rnd%0d depth", n), int'(stackDepth), m_dp);
      check($sformatf("rnd%0d ovf", n), int'(stackOvf), m_ov);
      check($sformatf("rnd%0d unf", n), int'(stackUnf), m_un);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
